// File: rtl/vec_pkg.sv
// Shared types and defaults for the vector lane sequencer and its ALU.
package vec_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 5;
    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned NUM_ELE_DEF    = 32;

    // Vector arithmetic opcodes carried on cmd_op.
    typedef enum logic [2:0] {
        VEC_OP_ADD = 3'd0,
        VEC_OP_SUB = 3'd1,
        VEC_OP_AND = 3'd2,
        VEC_OP_OR  = 3'd3,
        VEC_OP_XOR = 3'd4,
        VEC_OP_MUL = 3'd5,
        VEC_OP_MIN = 3'd6,
        VEC_OP_MAX = 3'd7
    } vec_op_t;

    // Sequencer control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } vec_state_t;

endpackage

// File: rtl/vector_lane_alu.sv
// Combinational element ALU for the vector lane sequencer.
// Build option: VEC_LANE_MUL_EN enables VEC_OP_MUL (low half of the signed
// product); without it VEC_OP_MUL is reported as an illegal opcode.
module vector_lane_alu
    import vec_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  vec_op_t               op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  illegal
);

    // Element result: all arithmetic wraps modulo 2^DATA_WIDTH.
    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (op)
            VEC_OP_ADD: result = a + b;
            VEC_OP_SUB: result = a - b;
            VEC_OP_AND: result = a & b;
            VEC_OP_OR:  result = a | b;
            VEC_OP_XOR: result = a ^ b;
            VEC_OP_MUL: begin
`ifdef VEC_LANE_MUL_EN
                result = DATA_WIDTH'($signed(a) * $signed(b));
`else
                illegal = 1'b1;
`endif
            end
            VEC_OP_MIN: result = ($signed(a) < $signed(b)) ? a : b;
            VEC_OP_MAX: result = ($signed(a) > $signed(b)) ? a : b;
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/vector_lane_sequencer.sv
// Element-serial vector command sequencer. Accepts one command at a time,
// walks elements 0..vl-1 through the register file's two combinational read
// ports and writes each result back one cycle later through the write port.
// Build option: VEC_LANE_MUL_EN (forwarded to vector_lane_alu) makes opcode 5
// legal; otherwise an opcode-5 command completes with err and no writes.
module vector_lane_sequencer
    import vec_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned NUM_ELE    = NUM_ELE_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_vd,
    input  logic [ADDR_WIDTH-1:0] cmd_vs1,
    input  logic [ADDR_WIDTH-1:0] cmd_vs2,
    input  logic [ADDR_WIDTH:0]   cmd_vl,
    output logic [ADDR_WIDTH-1:0] rAddr1_1,
    output logic [ADDR_WIDTH-1:0] rAddr2_1,
    input  logic [DATA_WIDTH-1:0] rData1,
    output logic [ADDR_WIDTH-1:0] rAddr1_2,
    output logic [ADDR_WIDTH-1:0] rAddr2_2,
    input  logic [DATA_WIDTH-1:0] rData2,
    output logic [ADDR_WIDTH-1:0] wAddr1,
    output logic [ADDR_WIDTH-1:0] wAddr2,
    output logic [DATA_WIDTH-1:0] wData,
    output logic                  wEnable,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [ADDR_WIDTH:0] MAX_VL = (ADDR_WIDTH + 1)'(NUM_ELE);

    vec_state_t            state_q, state_d;
    vec_op_t               op_q, op_d;
    logic [ADDR_WIDTH-1:0] vd_q, vd_d;
    logic [ADDR_WIDTH-1:0] vs1_q, vs1_d;
    logic [ADDR_WIDTH-1:0] vs2_q, vs2_d;
    logic [ADDR_WIDTH:0]   vl_q, vl_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  illegal_q, illegal_d;

    logic [ADDR_WIDTH-1:0] waddr1_q, waddr1_d;
    logic [ADDR_WIDTH-1:0] waddr2_q, waddr2_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wen_q, wen_d;

    logic [ADDR_WIDTH:0]   vl_clamped;
    logic                  last_elem;
    vec_op_t               alu_op;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_illegal;

    // Command decode helpers: clamped length, last-element detect, ALU opcode.
    // The ALU sees the offered opcode while idle so its illegal flag doubles
    // as the accept-time legality check; otherwise it runs the latched opcode.
    always_comb begin
        vl_clamped = (cmd_vl > MAX_VL) ? MAX_VL : cmd_vl;
        last_elem  = ({1'b0, idx_q} == (vl_q - 1'b1));
        alu_op     = (state_q == ST_IDLE) ? vec_op_t'(cmd_op) : op_q;
    end

    vector_lane_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .op      (alu_op),
        .a       (rData1),
        .b       (rData2),
        .result  (alu_result),
        .illegal (alu_illegal)
    );

    // State, latched command and registered write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= VEC_OP_ADD;
            vd_q      <= '0;
            vs1_q     <= '0;
            vs2_q     <= '0;
            vl_q      <= '0;
            idx_q     <= '0;
            illegal_q <= 1'b0;
            waddr1_q  <= '0;
            waddr2_q  <= '0;
            wdata_q   <= '0;
            wen_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            vd_q      <= vd_d;
            vs1_q     <= vs1_d;
            vs2_q     <= vs2_d;
            vl_q      <= vl_d;
            idx_q     <= idx_d;
            illegal_q <= illegal_d;
            waddr1_q  <= waddr1_d;
            waddr2_q  <= waddr2_d;
            wdata_q   <= wdata_d;
            wen_q     <= wen_d;
        end
    end

    // Next state: accept in IDLE, step idx in RUN, then DRAIN and DONE.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        vd_d      = vd_q;
        vs1_d     = vs1_q;
        vs2_d     = vs2_q;
        vl_d      = vl_q;
        idx_d     = idx_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d      = vec_op_t'(cmd_op);
                    vd_d      = cmd_vd;
                    vs1_d     = cmd_vs1;
                    vs2_d     = cmd_vs2;
                    vl_d      = vl_clamped;
                    idx_d     = '0;
                    illegal_d = alu_illegal;
                    if ((vl_clamped == '0) || alu_illegal) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                idx_d = idx_q + 1'b1;
                if (last_elem) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs: handshake/status, read addresses, and the next write-port values.
    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        err       = (state_q == ST_DONE) && illegal_q;
        rAddr1_1  = '0;
        rAddr2_1  = '0;
        rAddr1_2  = '0;
        rAddr2_2  = '0;
        waddr1_d  = waddr1_q;
        waddr2_d  = waddr2_q;
        wdata_d   = wdata_q;
        wen_d     = 1'b0;
        if (state_q == ST_RUN) begin
            rAddr1_1 = vs1_q;
            rAddr2_1 = idx_q;
            rAddr1_2 = vs2_q;
            rAddr2_2 = idx_q;
            waddr1_d = vd_q;
            waddr2_d = idx_q;
            wdata_d  = alu_result;
            wen_d    = 1'b1;
        end
    end

    assign wAddr1  = waddr1_q;
    assign wAddr2  = waddr2_q;
    assign wData   = wdata_q;
    assign wEnable = wen_q;

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Self-checking bench for vector_lane_sequencer with a behavioural register
// file (combinational reads, write on clock edge). Honours VEC_LANE_MUL_EN.
module tb_vector_lane_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_vd, cmd_vs1, cmd_vs2;
    logic [5:0]  cmd_vl;
    logic [4:0]  rAddr1_1, rAddr2_1, rAddr1_2, rAddr2_2;
    logic [31:0] rData1, rData2;
    logic [4:0]  wAddr1, wAddr2;
    logic [31:0] wData;
    logic        wEnable, busy, done, err;

    logic [31:0] mem [0:31][0:31];

    int  total = 0;
    int  bad   = 0;
    int  wr_cnt = 0;
    int  wr_rel [0:63];
    int  wr_ele [0:63];
    time t_acc = 0;

    always #5 clk = ~clk;

    vector_lane_sequencer #(
        .ADDR_WIDTH (5),
        .DATA_WIDTH (32),
        .NUM_ELE    (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_vd    (cmd_vd),
        .cmd_vs1   (cmd_vs1),
        .cmd_vs2   (cmd_vs2),
        .cmd_vl    (cmd_vl),
        .rAddr1_1  (rAddr1_1),
        .rAddr2_1  (rAddr2_1),
        .rData1    (rData1),
        .rAddr1_2  (rAddr1_2),
        .rAddr2_2  (rAddr2_2),
        .rData2    (rData2),
        .wAddr1    (wAddr1),
        .wAddr2    (wAddr2),
        .wData     (wData),
        .wEnable   (wEnable),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    assign rData1 = mem[rAddr1_1][rAddr2_1];
    assign rData2 = mem[rAddr1_2][rAddr2_2];

    // Register file write port plus a log of writes relative to the accept edge.
    always @(posedge clk) begin
        if (wEnable) begin
            mem[wAddr1][wAddr2] <= wData;
            if (wr_cnt < 64) begin
                wr_rel[wr_cnt] = int'(($time - t_acc) / 10);
                wr_ele[wr_cnt] = int'(wAddr2);
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        exp_err;
    } vec_t;

    vec_t tbl [0:9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic setm(input int r, input int e, input logic [31:0] v);
        mem[r][e] <= v;
    endtask

    // Offer a command until accepted; returns just after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [4:0] vd, input logic [4:0] vs1,
                         input logic [4:0] vs2, input logic [5:0] vl);
        int n;
        n = 0;
        cmd_op    = op;
        cmd_vd    = vd;
        cmd_vs1   = vs1;
        cmd_vs2   = vs2;
        cmd_vl    = vl;
        cmd_valid = 1'b1;
        do begin
            @(negedge clk);
            n = n + 1;
        end while (!cmd_ready && n < 200);
        if (!cmd_ready) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL accept_timeout actual=cmd_ready_low required=cmd_ready_high");
        end
        wr_cnt = 0;
        @(posedge clk);
        t_acc = $time;
        #1 cmd_valid = 1'b0;
    endtask

    // Cycles after the accept edge until done is seen (-1 on timeout).
    task automatic wait_done(output int n, output logic e);
        bit found;
        found = 0;
        n = 0;
        e = 1'b0;
        while (!found && n < 200) begin
            @(negedge clk);
            n = n + 1;
            if (done) begin
                found = 1;
                e = err;
            end
        end
        if (!found) n = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int   n;
        logic e;
        int   errs;
        time  t1;

        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0; cmd_vd = '0; cmd_vs1 = '0; cmd_vs2 = '0; cmd_vl = '0;
        for (int r = 0; r < 32; r++)
            for (int i = 0; i < 32; i++) setm(r, i, 32'hDEADBEEF);

        tbl[0] = '{3'd0, 32'd5,          32'd7,          32'd12,         1'b0};
        tbl[1] = '{3'd1, 32'd0,          32'd1,          32'hFFFFFFFF,   1'b0};
        tbl[2] = '{3'd2, 32'hF0F0F0F0,   32'h0FF00FF0,   32'h00F000F0,   1'b0};
        tbl[3] = '{3'd3, 32'hF0000000,   32'h0000000F,   32'hF000000F,   1'b0};
        tbl[4] = '{3'd4, 32'hAAAA5555,   32'hFFFF0000,   32'h55555555,   1'b0};
`ifdef VEC_LANE_MUL_EN
        tbl[5] = '{3'd5, 32'hFFFFFFFD,   32'd7,          32'hFFFFFFEB,   1'b0};
`else
        tbl[5] = '{3'd5, 32'hFFFFFFFD,   32'd7,          32'hDEADBEEF,   1'b1};
`endif
        tbl[6] = '{3'd6, 32'hFFFFFFFF,   32'd0,          32'hFFFFFFFF,   1'b0};
        tbl[7] = '{3'd7, 32'hFFFFFFFF,   32'd0,          32'd0,          1'b0};
        tbl[8] = '{3'd7, 32'd7,          32'd3,          32'd7,          1'b0};
        tbl[9] = '{3'd6, 32'd5,          32'd2,          32'd2,          1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_wEnable", wEnable, 0);
        chk("rst_wdata", {wAddr1, wAddr2, wData}, 0);
        chk("rst_raddr", {rAddr1_1, rAddr2_1, rAddr1_2, rAddr2_2}, 0);
        reset = 1'b0;

        // Basic ADD: reg3 = reg1 + reg2, vl=4
        for (int i = 0; i < 4; i++) begin
            setm(1, i, 32'(i + 1));
            setm(2, i, 32'(10 * (i + 1)));
        end
        issue(3'd0, 5'd3, 5'd1, 5'd2, 6'd4);
        wait_done(n, e);
        chk("add_done_cycle", n, 6);
        chk("add_err", e, 0);
        chk("add_wr_cnt", wr_cnt, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("add_data%0d", i), mem[3][i], 32'(11 * (i + 1)));
            chk($sformatf("add_wr_cycle%0d", i), wr_rel[i], 2 + i);
            chk($sformatf("add_wr_elem%0d", i), wr_ele[i], i);
        end
        chk("add_untouched", mem[3][4], 32'hDEADBEEF);

        // Opcode table, vl=1, result into reg4 element 0
        for (int k = 0; k < 10; k++) begin
            setm(1, 0, tbl[k].a);
            setm(2, 0, tbl[k].b);
            setm(4, 0, 32'hDEADBEEF);
            issue(tbl[k].op, 5'd4, 5'd1, 5'd2, 6'd1);
            wait_done(n, e);
            chk($sformatf("tbl%0d_result", k), mem[4][0], tbl[k].exp);
            chk($sformatf("tbl%0d_err", k), e, tbl[k].exp_err);
            chk($sformatf("tbl%0d_done_cycle", k), n, tbl[k].exp_err ? 1 : 3);
            chk($sformatf("tbl%0d_wr_cnt", k), wr_cnt, tbl[k].exp_err ? 0 : 1);
        end

        // vl=0: immediate done, no writes
        issue(3'd0, 5'd9, 5'd1, 5'd2, 6'd0);
        wait_done(n, e);
        chk("vl0_done_cycle", n, 1);
        chk("vl0_err", e, 0);
        chk("vl0_wr_cnt", wr_cnt, 0);

        // vl=40 clamps to 32
        for (int i = 0; i < 32; i++) begin
            setm(1, i, 32'(i));
            setm(2, i, 32'(2 * i));
        end
        issue(3'd0, 5'd10, 5'd1, 5'd2, 6'd40);
        wait_done(n, e);
        chk("vl40_done_cycle", n, 34);
        chk("vl40_wr_cnt", wr_cnt, 32);
        chk("vl40_last_elem", wr_ele[31], 31);
        errs = 0;
        for (int i = 0; i < 32; i++) if (mem[10][i] !== 32'(3 * i)) errs++;
        chk("vl40_data_errs", errs, 0);

        // In-place XOR then a back-to-back SUB held valid throughout
        for (int i = 0; i < 32; i++) begin
            setm(1, i, 32'(i + 1));
            setm(2, i, 32'(i) * 32'h01010101 + 32'd5);
        end
        issue(3'd4, 5'd2, 5'd2, 5'd2, 6'd32);
        t1 = t_acc;
        cmd_op = 3'd1; cmd_vd = 5'd6; cmd_vs1 = 5'd2; cmd_vs2 = 5'd1; cmd_vl = 6'd32;
        cmd_valid = 1'b1;
        wait_done(n, e);
        chk("xor_done_cycle", n, 34);
        chk("xor_wr_cnt", wr_cnt, 32);
        errs = 0;
        for (int i = 0; i < 32; i++) if (mem[2][i] !== 32'd0) errs++;
        chk("xor_nonzero", errs, 0);
        issue(3'd1, 5'd6, 5'd2, 5'd1, 6'd32);
        chk("b2b_accept_gap", int'((t_acc - t1) / 10), 35);
        wait_done(n, e);
        chk("b2b_done_cycle", n, 34);
        chk("b2b_wr_cnt", wr_cnt, 32);
        errs = 0;
        for (int i = 0; i < 32; i++) if (mem[6][i] !== 32'd0 - 32'(i + 1)) errs++;
        chk("b2b_data_errs", errs, 0);

        // Reset one cycle at T+10 in a 32-element ADD
        for (int i = 0; i < 32; i++) begin
            setm(1, i, 32'(i));
            setm(2, i, 32'd100);
            setm(8, i, 32'hDEADBEEF);
        end
        issue(3'd0, 5'd8, 5'd1, 5'd2, 6'd32);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid_wEnable", wEnable, 0);
        chk("rstmid_cmd_ready", cmd_ready, 1);
        chk("rstmid_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("rstmid_wr_cnt", wr_cnt, 9);
        errs = 0;
        for (int i = 0; i < 32; i++) begin
            if (i < 9) begin
                if (mem[8][i] !== 32'(i + 100)) errs++;
            end else begin
                if (mem[8][i] !== 32'hDEADBEEF) errs++;
            end
        end
        chk("rstmid_data_errs", errs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vector_lane_sequencer.md
Name: vector_lane_sequencer

Overview:
Element-serial execution sequencer for the vector coprocessor. It accepts one vector arithmetic command at a time and walks element indices 0..vl-1. For each element it reads two source elements through the register file's two combinational read ports and computes the result. The result is written back through the file's single write port one cycle later. It sits directly upstream of the vector register file and drives all of its read and write address/data/enable ports.

Parameters:
ADDR_WIDTH, 5, width of register-index and element-index fields.
DATA_WIDTH, 32, element width.
NUM_ELE, 32, elements per vector register; max legal vl.

Ports:
clk  in  1  clock
reset  in  1  reset; synchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept; high only in IDLE
cmd_op  in  3  opcode (VEC_OP_*)
cmd_vd  in  ADDR_WIDTH  destination register
cmd_vs1  in  ADDR_WIDTH  source register 1
cmd_vs2  in  ADDR_WIDTH  source register 2
cmd_vl  in  ADDR_WIDTH+1  vector length 0..NUM_ELE
rAddr1_1  out  ADDR_WIDTH  read port 1 register index
rAddr2_1  out  ADDR_WIDTH  read port 1 element index
rData1  in  DATA_WIDTH  read port 1 data (combinational from file)
rAddr1_2  out  ADDR_WIDTH  read port 2 register index
rAddr2_2  out  ADDR_WIDTH  read port 2 element index
rData2  in  DATA_WIDTH  read port 2 data
wAddr1  out  ADDR_WIDTH  write register index (registered)
wAddr2  out  ADDR_WIDTH  write element index (registered)
wData  out  DATA_WIDTH  write data (registered)
wEnable  out  1  write strobe (registered)
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at command completion
err  out  1  one-cycle pulse with done for an illegal opcode

Behaviour:
- Reset values:
  - All outputs are 0, except cmd_ready=1.
  - FSM is in IDLE.
  - idx and latched command registers are 0.
- Reset is sampled on the clk edge only. Asserting reset mid-command aborts it; from the next cycle wEnable=0 and state=IDLE. Partial writes already performed remain in the file.
- Accept: on a clk edge with cmd_valid && cmd_ready, latch op, vd, vs1, vs2, and vl.
  - vl > NUM_ELE is clamped to NUM_ELE.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on accept with vl>0 and a legal op.
  - IDLE -> DONE on accept with vl==0 or an illegal op. No writes are made; err=1 in DONE for an illegal op.
  - RUN:
    - Drive rAddr1_1=vs1, rAddr1_2=vs2, and rAddr2_1=rAddr2_2=idx.
    - Compute alu(op, rData1, rData2) combinationally.
    - Register {wAddr1=vd, wAddr2=idx, wData=result, wEnable=1}.
    - idx increments each cycle. When idx==vl-1, go to DRAIN.
  - DRAIN: the final write is presented (wEnable=1). Next registered wEnable=0. Go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
  - In IDLE and DONE, read addresses are driven to 0.
- Latency: accept at edge T; element i is read in cycle T+1+i and written in cycle T+2+i. done is high in cycle T+vl+2, or T+1 when vl==0.
- Throughput: one element per cycle. The next command can be accepted on the edge ending the cycle after done.
- Hazard: vd may equal vs1 or vs2. Element i is read before its own write and is never re-read, so no forwarding is needed.
- Arithmetic: DATA_WIDTH-bit, results wrap modulo 2^DATA_WIDTH, no flags.
  - 0 ADD; 1 SUB (a-b); 2 AND; 3 OR; 4 XOR; 5 MUL (low half); 6 MIN signed; 7 MAX signed.
- Commands presented while busy are ignored (cmd_ready=0). Upstream holds cmd_valid until accepted.

Optional Feature:
VEC_LANE_MUL_EN
- Defined: opcode 5 computes the low DATA_WIDTH bits of the signed product.
- Undefined: opcode 5 is illegal. The command is accepted, nothing is written, and done and err pulse together.

Decomposition:
- Shared package vec_pkg holds:
  - opcode constants VEC_OP_ADD..VEC_OP_MAX as a 3-bit typedef vec_op_t;
  - the FSM state typedef;
  - NUM_ELE and ADDR_WIDTH defaults.
- One sub-module, vector_lane_alu: purely combinational (op, a, b) -> result, plus illegal-op flag.

Test Plan:
- Basic ADD: reg1=[1,2,3,4], reg2=[10,20,30,40], ADD vd=3, vl=4, accept at T -> writes of 11,22,33,44 to reg3 elems 0..3 in cycles T+2..T+5; done at T+6; reg3[4] untouched.
- SUB wrap: reg1[0]=0, reg2[0]=1, vl=1 -> wData=32'hFFFFFFFF; MIN gives 32'hFFFFFFFF vs 0 -> FFFFFFFF (signed).
- vl=0 and vl=40: vl=0 -> done at T+1 with no wEnable; vl=40 -> clamped, exactly 32 writes, last wAddr2=31.
- In-place and back-to-back: XOR vd=vs1=vs2=2, vl=32 -> reg2 all zero. A second command held valid throughout is accepted on the edge after done and writes correctly.
- Reset mid-run: ADD vl=32, assert reset for one cycle at T+10 -> from T+11 wEnable=0, cmd_ready=1; elems 0..8 written, elems 9..31 unchanged.
- MUL opcode: reg1[0]=-3, reg2[0]=7 -> with VEC_LANE_MUL_EN, wData=-21; without it, no write, and done=err=1 at T+1.
